pipe_hazard_ctrl: RTL and testbench

- Produces the write-enable and flush controls consumed by the F/D, D/E and E/M pipeline registers of the 5-stage CPU.
- Detects data hazards with the Tuse/Tnew scheme, then freezes F and D and inserts a bubble into E.
- Owns a multi-cycle busy counter for the mult/div unit. An MDU-class instruction in D stalls while the unit is busy.
- Keeps a saturating count of stall cycles for performance debug.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 45 ++++
 rtl/pipe_hazard_ctrl_mdu_busy_timer.sv | 53 +++++
 rtl/pipe_hazard_ctrl.sv | 97 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
//   Shared CPU constants for the hazard controller and the instruction
//   decoder. It holds the GRF address width, the Tuse/Tnew encodings, the
//   default MDU latencies, and the per-source data-hazard comparison.
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam int GRF_AW = 5;

    typedef logic [GRF_AW-1:0] grf_addr_t;
    typedef logic [1:0]        t_stage_t;

    // Tuse: cycles until the D-stage instruction consumes an operand.
    localparam t_stage_t TUSE_0    = 2'd0;
    localparam t_stage_t TUSE_1    = 2'd1;
    localparam t_stage_t TUSE_2    = 2'd2;
    localparam t_stage_t TUSE_NONE = 2'd3;   // operand not read at all

    // Tnew: cycles until a producer's result can be forwarded (never > 2).
    localparam t_stage_t TNEW_0 = 2'd0;
    localparam t_stage_t TNEW_1 = 2'd1;
    localparam t_stage_t TNEW_2 = 2'd2;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // A D-stage source must wait when an in-flight producer writes the same
    // register but cannot deliver it before the consumer needs it. $0 is
    // hard-wired, so a "write" to $0 never creates a hazard. TUSE_NONE never
    // stalls because Tnew tops out at 2.
    function automatic logic src_hazard(
        input grf_addr_t src,
        input t_stage_t  tuse,
        input grf_addr_t e_waddr,
        input t_stage_t  e_tnew,
        input grf_addr_t m_waddr,
        input t_stage_t  m_tnew
    );
        return (src != '0) &&
               (((src == e_waddr) && (e_tnew > tuse)) ||
                ((src == m_waddr) && (m_tnew > tuse)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_mdu_busy_timer.sv
// ---------------------------------------------------------------------------
// mdu_busy_timer
//   Busy counter for the multi-cycle mult/div unit. A start loads the
//   latency of its class, and a later start reloads the counter (the newest
//   start wins). The counter then counts down to zero.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   e_start     : E-stage instruction is mult/multu/div/divu
//   e_is_div    : qualifies e_start, 1 = div class, 0 = mult class
//   mdu_busy    : counter is nonzero
// ---------------------------------------------------------------------------
module mdu_busy_timer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4    // 2**CNT_W must exceed both latencies
) (
    input  logic clk,
    input  logic reset,
    input  logic e_start,
    input  logic e_is_div,
    output logic mdu_busy
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] busy_cnt_q;
    logic [CNT_W-1:0] busy_cnt_d;

    always_comb begin
        // NOTE: give every always_comb target a default first, so that no
        // path leaves it unassigned and infers a latch.
        busy_cnt_d = busy_cnt_q;
        if (e_start) begin
            busy_cnt_d = e_is_div ? DIV_LD : MULT_LD;
        end else if (busy_cnt_q != '0) begin
            busy_cnt_d = busy_cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments. All flops then
    // sample their pre-edge values, and the simulation matches the hardware.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cnt_q <= '0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign mdu_busy = (busy_cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Stall/flush control for the F/D, D/E and E/M pipeline registers of the
//   5-stage CPU. It detects Tuse/Tnew data hazards and MDU-busy hazards. On
//   a stall it freezes F and D and injects a bubble into E. It also keeps a
//   saturating count of stall cycles for performance debug.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   d_rs, d_rt            : D-stage source register addresses
//   d_tuse_rs, d_tuse_rt  : Tuse per source (3 = unused)
//   d_is_mdu              : D-stage instruction uses the MDU
//   e_waddr, e_tnew       : E-stage destination and its Tnew (waddr 0 = none)
//   m_waddr, m_tnew       : M-stage destination and its Tnew (waddr 0 = none)
//   e_start, e_is_div     : MDU start in E and its class
//   f_we, d_we            : PC/F-D write enable and D-E advance enable
//   e_flush               : clear the D/E register (bubble)
//   mdu_busy              : MDU busy-counter nonzero
//   stall_count           : saturating count of stalled cycles
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [GRF_AW-1:0] d_rs,
    input  logic [GRF_AW-1:0] d_rt,
    input  logic [1:0]        d_tuse_rs,
    input  logic [1:0]        d_tuse_rt,
    input  logic              d_is_mdu,
    input  logic [GRF_AW-1:0] e_waddr,
    input  logic [1:0]        e_tnew,
    input  logic [GRF_AW-1:0] m_waddr,
    input  logic [1:0]        m_tnew,
    input  logic              e_start,
    input  logic              e_is_div,
    output logic              f_we,
    output logic              d_we,
    output logic              e_flush,
    output logic              mdu_busy,
    output logic [31:0]       stall_count
);

    logic stall_rs;
    logic stall_rt;
    logic stall_mdu;
    logic stall;

    logic [31:0] stall_count_q;
    logic [31:0] stall_count_d;

    mdu_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_mdu_busy_timer (
        .clk      (clk),
        .reset    (reset),
        .e_start  (e_start),
        .e_is_div (e_is_div),
        .mdu_busy (mdu_busy)
    );

    always_comb begin
        stall_rs  = src_hazard(d_rs, d_tuse_rs, e_waddr, e_tnew, m_waddr, m_tnew);
        stall_rt  = src_hazard(d_rt, d_tuse_rt, e_waddr, e_tnew, m_waddr, m_tnew);
        // e_start also counts: the start instruction sitting in E has not yet
        // loaded the busy counter, but the unit is already committed.
        stall_mdu = d_is_mdu && (mdu_busy || e_start);
        stall     = stall_rs | stall_rt | stall_mdu;
    end

    assign f_we    = ~stall;
    assign d_we    = ~stall;
    assign e_flush = stall;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  d_rs, d_rt, e_waddr, m_waddr;
    logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic        d_is_mdu, e_start, e_is_div;
    logic        f_we, d_we, e_flush, mdu_busy;
    logic [31:0] stall_count;

    pipe_hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .d_rs        (d_rs),
        .d_rt        (d_rt),
        .d_tuse_rs   (d_tuse_rs),
        .d_tuse_rt   (d_tuse_rt),
        .d_is_mdu    (d_is_mdu),
        .e_waddr     (e_waddr),
        .e_tnew      (e_tnew),
        .m_waddr     (m_waddr),
        .m_tnew      (m_tnew),
        .e_start     (e_start),
        .e_is_div    (e_is_div),
        .f_we        (f_we),
        .d_we        (d_we),
        .e_flush     (e_flush),
        .mdu_busy    (mdu_busy),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] rs, rt, ew, mw;
        logic [1:0] urs, urt, et, mt;
        logic       mdu, st, dv;
    } stim_t;

    typedef struct {
        string       name;
        logic        stall;
        logic        busy;
        logic [31:0] sc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b0; s.rs = '0; s.rt = '0; s.ew = '0; s.mw = '0;
        s.urs = 2'd3; s.urt = 2'd3; s.et = '0; s.mt = '0;
        s.mdu = 1'b0; s.st = 1'b0; s.dv = 1'b0;
        return s;
    endfunction

    // Drive one cycle of inputs just after the edge and queue the expected
    // response for the monitor.
    task automatic apply(input string name, input stim_t s,
                         input logic exp_stall, input logic exp_busy,
                         input logic [31:0] exp_sc);
        exp_t e;
        @(posedge clk);
        #1;
        reset = s.rst; d_rs = s.rs; d_rt = s.rt; e_waddr = s.ew; m_waddr = s.mw;
        d_tuse_rs = s.urs; d_tuse_rt = s.urt; e_tnew = s.et; m_tnew = s.mt;
        d_is_mdu = s.mdu; e_start = s.st; e_is_div = s.dv;
        e.name = name; e.stall = exp_stall; e.busy = exp_busy; e.sc = exp_sc;
        q.push_back(e);
    endtask

    // Monitor: outputs are combinational, so sample mid-cycle.
    initial begin
        exp_t e;
        logic [3:0] got_ctl, exp_ctl;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                got_ctl = {f_we, d_we, e_flush, mdu_busy};
                exp_ctl = {~e.stall, ~e.stall, e.stall, e.busy};
                checks++;
                if (got_ctl !== exp_ctl) begin
                    failures++;
                    $display("FAIL %s ctl{f_we,d_we,e_flush,busy}: got %b want %b",
                             e.name, got_ctl, exp_ctl);
                end
                checks++;
                if (stall_count !== e.sc) begin
                    failures++;
                    $display("FAIL %s stall_count: got %0d want %0d",
                             e.name, stall_count, e.sc);
                end
            end
        end
    end

    initial begin
        stim_t s;
        int    sc;
        reset = 1'b1; d_rs = '0; d_rt = '0; e_waddr = '0; m_waddr = '0;
        d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; e_tnew = '0; m_tnew = '0;
        d_is_mdu = 1'b0; e_start = 1'b0; e_is_div = 1'b0;

        s = idle(); s.rst = 1'b1;
        apply("reset", s, 1'b0, 1'b0, 0);
        s = idle();
        apply("idle", s, 1'b0, 1'b0, 0);

        // lw -> use, then forwardable from M on the next cycle.
        s = idle(); s.ew = 5'd1; s.et = 2'd2; s.rs = 5'd1; s.urs = 2'd1;
        apply("lw_use", s, 1'b1, 1'b0, 0);
        s = idle(); s.mw = 5'd1; s.mt = 2'd1; s.rs = 5'd1; s.urs = 2'd1;
        apply("lw_fwd_m", s, 1'b0, 1'b0, 1);

        s = idle(); s.ew = 5'd3; s.et = 2'd1; s.rt = 5'd3; s.urt = 2'd1;
        apply("rt_fwd", s, 1'b0, 1'b0, 1);
        s.urt = 2'd0;
        apply("rt_tuse0", s, 1'b1, 1'b0, 1);

        s = idle(); s.ew = 5'd0; s.et = 2'd2; s.rs = 5'd0; s.urs = 2'd0;
        apply("reg0", s, 1'b0, 1'b0, 2);
        s = idle(); s.ew = 5'd5; s.et = 2'd2; s.rs = 5'd5; s.urs = 2'd3;
        apply("tuse_none", s, 1'b0, 1'b0, 2);
        s = idle(); s.mw = 5'd7; s.mt = 2'd2; s.rt = 5'd7; s.urt = 2'd1;
        apply("m_rt_stall", s, 1'b1, 1'b0, 2);

        // mult start with an mfhi in D: start cycle + 5 busy cycles.
        s = idle(); s.mdu = 1'b1; s.st = 1'b1; s.dv = 1'b0;
        apply("mult_start", s, 1'b1, 1'b0, 3);
        s = idle(); s.mdu = 1'b1;
        for (int i = 0; i < 5; i++) apply("mult_busy", s, 1'b1, 1'b1, 4 + i);
        apply("mult_done", s, 1'b0, 1'b0, 9);

        // div start, then mult restart when the counter reads 4.
        s = idle(); s.st = 1'b1; s.dv = 1'b1;
        apply("div_start", s, 1'b0, 1'b0, 9);
        s = idle();
        for (int i = 0; i < 6; i++) apply("div_busy", s, 1'b0, 1'b1, 9);
        s = idle(); s.st = 1'b1; s.dv = 1'b0;
        apply("restart_at4", s, 1'b0, 1'b1, 9);
        s = idle();
        for (int i = 0; i < 5; i++) apply("reload_busy", s, 1'b0, 1'b1, 9);
        apply("reload_done", s, 1'b0, 1'b0, 9);

        // A lone div holds busy for exactly 10 cycles.
        s = idle(); s.st = 1'b1; s.dv = 1'b1;
        apply("div10_start", s, 1'b0, 1'b0, 9);
        s = idle();
        for (int i = 0; i < 10; i++) apply("div10_busy", s, 1'b0, 1'b1, 9);
        apply("div10_done", s, 1'b0, 1'b0, 9);

        // Reset in the middle of a div: counter reads 7 when reset lands,
        // and reset beats a simultaneous e_start.
        s = idle(); s.mdu = 1'b1; s.st = 1'b1; s.dv = 1'b1;
        apply("rdiv_start", s, 1'b1, 1'b0, 9);
        s = idle(); s.mdu = 1'b1;
        sc = 10;
        for (int i = 0; i < 3; i++) begin
            apply("rdiv_busy", s, 1'b1, 1'b1, 32'(sc));
            sc++;
        end
        s = idle(); s.mdu = 1'b1; s.rst = 1'b1; s.st = 1'b1; s.dv = 1'b1;
        apply("rdiv_reset", s, 1'b1, 1'b1, 13);
        s = idle(); s.mdu = 1'b1;
        apply("after_reset", s, 1'b0, 1'b0, 0);

        // Data and MDU stall together are counted once.
        s = idle(); s.mdu = 1'b1; s.st = 1'b1; s.ew = 5'd2; s.et = 2'd2;
        s.rs = 5'd2; s.urs = 2'd0;
        apply("dual_stall", s, 1'b1, 1'b0, 0);
        s = idle();
        apply("dual_after", s, 1'b0, 1'b1, 1);

        // Let the monitor drain, with a bounded wait.
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
